fpu_mult_iter_hs: RTL

- Parametrised IEEE-754 floating-point multiplier for single or double precision.
- Significand product is computed iteratively, RB bits per cycle, so area and latency are traded by parameter.
- Adds valid/ready handshakes, all four rounding modes, special-value handling (zero/inf/NaN), and an inexact/invalid flag set.
- Sits between operand-issue logic and result writeback in the FPU datapath.

---
 rtl/fpu_mult_pkg.sv | 42 ++++
 rtl/sgf_iter_multiplier.sv | 90 +++++++++
 rtl/fpu_mult_iter_hs.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mult_pkg.sv
// Shared types, rounding-mode codes, flag bit positions and format helpers
// for the iterative floating-point multiplier.
package fpu_mult_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_UNPACK = 3'd1,
      ST_MULT   = 3'd2,
      ST_NORM   = 3'd3,
      ST_ROUND  = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   localparam logic [1:0] RM_RNE  = 2'b00;
   localparam logic [1:0] RM_RTZ  = 2'b01;
   localparam logic [1:0] RM_PINF = 2'b10;
   localparam logic [1:0] RM_NINF = 2'b11;

   localparam int FLG_INEXACT   = 0;
   localparam int FLG_UNDERFLOW = 1;
   localparam int FLG_OVERFLOW  = 2;
   localparam int FLG_INVALID   = 3;

   function automatic int bias(input int ew);
      return (1 << (ew - 1)) - 1;
   endfunction

   // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
   function automatic logic [63:0] qnan(input int w, input int ew, input int sw);
      logic [63:0] r;
      r = 64'd0;
      for (int i = 0; i < 64; i++) begin
         if (i < w) begin
            r[i] = ((i >= sw) && (i < sw + ew)) || (i == sw - 1);
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sgf_iter_multiplier.sv
// Iterative unsigned significand multiplier: RB multiplier bits retired per
// cycle; done_o pulses for one cycle once the final partial product is added.
module sgf_iter_multiplier
#(
   parameter int MW = 24,
   parameter int RB = 4
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [MW-1:0]   a_i,
   input  logic [MW-1:0]   b_i,
   output logic            done_o,
   output logic [2*MW-1:0] prod_o
);

   localparam int N  = (MW + RB - 1) / RB;
   localparam int PW = N * RB;
   localparam int CW = $clog2(N + 1);

   logic [2*MW-1:0] acc_q, acc_d;
   logic [2*MW-1:0] mcand_q, mcand_d;
   logic [PW-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [2*MW-1:0] sum;

   // Next-state: load on start, otherwise add one RB-bit slice per cycle.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sum      = acc_q;
      if (start_i) begin
         acc_d    = {(2*MW){1'b0}};
         mcand_d  = (2*MW)'(a_i);
         mplier_d = PW'(b_i);
         cnt_d    = {CW{1'b0}};
         busy_d   = 1'b1;
      end else if (busy_q) begin
         for (int i = 0; i < RB; i++) begin
            if (mplier_q[i]) begin
               sum = sum + (mcand_q << i);
            end else begin
               sum = sum;
            end
         end
         acc_d    = sum;
         mcand_d  = mcand_q << RB;
         mplier_d = mplier_q >> RB;
         cnt_d    = cnt_q + CW'(1);
         if (cnt_q == CW'(N - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            busy_d = 1'b1;
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q    <= {(2*MW){1'b0}};
         mcand_q  <= {(2*MW){1'b0}};
         mplier_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign done_o = done_q;
   assign prod_o = acc_q;

endmodule

// File: rtl/fpu_mult_iter_hs.sv
// IEEE-754 multiplier with valid/ready handshakes, four rounding modes and
// exception flags. Optional sticky flag register: FPU_MULT_STICKY_FLAGS_EN.
module fpu_mult_iter_hs
   import fpu_mult_pkg::*;
#(
   parameter int W  = 32,
   parameter int EW = 8,
   parameter int SW = 23,
   parameter int RB = 4
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [W-1:0] data_x_i,
   input  logic [W-1:0] data_y_i,
   input  logic [1:0]   round_mode_i,
`ifdef FPU_MULT_STICKY_FLAGS_EN
   input  logic         flags_clr_i,
   output logic [3:0]   sticky_flags_o,
`endif
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [W-1:0] result_o,
   output logic         overflow_o,
   output logic         underflow_o,
   output logic         inexact_o,
   output logic         invalid_o
);

   localparam int                MW         = SW + 1;
   localparam int                BIAS       = bias(EW);
   localparam logic [63:0]       QNAN64     = qnan(W, EW, SW);
   localparam logic [W-1:0]      QNAN       = QNAN64[W-1:0];
   localparam logic signed [EW+1:0] EMAX    = (EW+2)'((1 << EW) - 1);
   localparam logic signed [EW+1:0] EXP_ONE = (EW+2)'(1);
   localparam logic signed [EW+1:0] EXP_ZRO = (EW+2)'(0);
   localparam logic signed [EW+1:0] EXP_BIAS = (EW+2)'(BIAS);
   localparam logic [EW-1:0]     EXP_MAXFIN = EW'((1 << EW) - 2);

   state_e                 state_q, state_d;
   logic [W-1:0]           x_q, x_d, y_q, y_d;
   logic [1:0]             rm_q, rm_d;
   logic                   sign_q, sign_d;
   logic signed [EW+1:0]   exp_q, exp_d;
   logic [MW-1:0]          mant_q, mant_d;
   logic                   g_q, g_d, s_q, s_d;
   logic [W-1:0]           res_q, res_d;
   logic [3:0]             flags_q, flags_d;
   logic                   out_valid_q, out_valid_d;
   logic                   in_ready_q, in_ready_d;

   logic                   accept, hs;
   logic [EW-1:0]          ex_x, ex_y;
   logic [SW-1:0]          fx_x, fx_y;
   logic                   x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, res_sign;
   logic signed [EW+1:0]   exp_sum;
   logic                   mul_done;
   logic [2*MW-1:0]        prod;

   logic [MW-1:0]          norm_mant;
   logic                   norm_g, norm_s, norm_inc;
   logic                   rnd_inc, to_inf;
   logic [MW:0]            mant_rnd;
   logic [SW-1:0]          frac_fin;
   logic signed [EW+1:0]   exp_fin;

   assign accept   = in_valid_i && in_ready_q;
   assign hs       = out_valid_q && out_ready_i;
   assign ex_x     = x_q[W-2:SW];
   assign ex_y     = y_q[W-2:SW];
   assign fx_x     = x_q[SW-1:0];
   assign fx_y     = y_q[SW-1:0];
   // Subnormal operands are flushed: a zero exponent classifies as zero.
   assign x_zero   = (ex_x == {EW{1'b0}});
   assign y_zero   = (ex_y == {EW{1'b0}});
   assign x_inf    = (&ex_x) && (fx_x == {SW{1'b0}});
   assign y_inf    = (&ex_y) && (fx_y == {SW{1'b0}});
   assign x_nan    = (&ex_x) && (|fx_x);
   assign y_nan    = (&ex_y) && (|fx_y);
   assign res_sign = x_q[W-1] ^ y_q[W-1];
   assign exp_sum  = $signed({2'b00, ex_x}) + $signed({2'b00, ex_y}) - EXP_BIAS;

   sgf_iter_multiplier #(.MW(MW), .RB(RB)) u_sgf (
      .clk     (clk),
      .rst     (rst),
      .start_i (accept),
      .a_i     ({1'b1, data_x_i[SW-1:0]}),
      .b_i     ({1'b1, data_y_i[SW-1:0]}),
      .done_o  (mul_done),
      .prod_o  (prod)
   );

   // Normalisation of the raw product into MW bits plus guard and sticky.
   always_comb begin
      if (prod[2*MW-1]) begin
         norm_mant = prod[2*MW-1 -: MW];
         norm_g    = prod[MW-1];
         norm_s    = |prod[MW-2:0];
         norm_inc  = 1'b1;
      end else begin
         norm_mant = prod[2*MW-2 -: MW];
         norm_g    = prod[MW-2];
         norm_s    = |prod[MW-3:0];
         norm_inc  = 1'b0;
      end
   end

   // Rounding increment, carry renormalisation and overflow target selection.
   always_comb begin
      case (rm_q)
         RM_RNE:  rnd_inc = g_q && (s_q || mant_q[0]);
         RM_RTZ:  rnd_inc = 1'b0;
         RM_PINF: rnd_inc = !sign_q && (g_q || s_q);
         RM_NINF: rnd_inc = sign_q && (g_q || s_q);
         default: rnd_inc = 1'b0;
      endcase
      mant_rnd = {1'b0, mant_q} + {{MW{1'b0}}, rnd_inc};
      if (mant_rnd[MW]) begin
         frac_fin = mant_rnd[MW-1:1];
         exp_fin  = exp_q + EXP_ONE;
      end else begin
         frac_fin = mant_rnd[MW-2:0];
         exp_fin  = exp_q;
      end
      to_inf = (rm_q == RM_RNE) || ((rm_q == RM_PINF) && !sign_q) ||
               ((rm_q == RM_NINF) && sign_q);
   end

   // Controller next-state and datapath register updates.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      rm_d        = rm_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      g_d         = g_q;
      s_d         = s_q;
      res_d       = res_q;
      flags_d     = flags_q;
      out_valid_d = out_valid_q;
      in_ready_d  = in_ready_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               x_d        = data_x_i;
               y_d        = data_y_i;
               rm_d       = round_mode_i;
               in_ready_d = 1'b0;
               state_d    = ST_UNPACK;
            end else begin
               in_ready_d = 1'b1;
            end
         end
         ST_UNPACK: begin
            sign_d  = res_sign;
            exp_d   = exp_sum;
            flags_d = 4'b0000;
            if (x_nan || y_nan || (x_inf && y_zero) || (x_zero && y_inf)) begin
               res_d                = QNAN;
               flags_d[FLG_INVALID] = 1'b1;
               state_d              = ST_DONE;
            end else if (x_inf || y_inf) begin
               res_d   = {res_sign, {EW{1'b1}}, {SW{1'b0}}};
               state_d = ST_DONE;
            end else if (x_zero || y_zero) begin
               res_d   = {res_sign, {(W-1){1'b0}}};
               state_d = ST_DONE;
            end else begin
               state_d = ST_MULT;
            end
         end
         ST_MULT: begin
            if (mul_done) begin
               state_d = ST_NORM;
            end else begin
               state_d = ST_MULT;
            end
         end
         ST_NORM: begin
            mant_d = norm_mant;
            g_d    = norm_g;
            s_d    = norm_s;
            if (norm_inc) begin
               exp_d = exp_q + EXP_ONE;
            end else begin
               exp_d = exp_q;
            end
            state_d = ST_ROUND;
         end
         ST_ROUND: begin
            flags_d = 4'b0000;
            if (exp_fin >= EMAX) begin
               flags_d[FLG_OVERFLOW] = 1'b1;
               flags_d[FLG_INEXACT]  = 1'b1;
               if (to_inf) begin
                  res_d = {sign_q, {EW{1'b1}}, {SW{1'b0}}};
               end else begin
                  res_d = {sign_q, EXP_MAXFIN, {SW{1'b1}}};
               end
            end else if (exp_fin <= EXP_ZRO) begin
               flags_d[FLG_UNDERFLOW] = 1'b1;
               flags_d[FLG_INEXACT]   = 1'b1;
               res_d = {sign_q, {(W-1){1'b0}}};
            end else begin
               flags_d[FLG_INEXACT] = g_q || s_q;
               res_d = {sign_q, exp_fin[EW-1:0], frac_fin};
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // out_valid rises one cycle after entering DONE and drops on the handshake.
            if (hs) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ST_IDLE;
            end else begin
               out_valid_d = 1'b1;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Controller and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         x_q         <= {W{1'b0}};
         y_q         <= {W{1'b0}};
         rm_q        <= 2'b00;
         sign_q      <= 1'b0;
         exp_q       <= EXP_ZRO;
         mant_q      <= {MW{1'b0}};
         g_q         <= 1'b0;
         s_q         <= 1'b0;
         res_q       <= {W{1'b0}};
         flags_q     <= 4'b0000;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         rm_q        <= rm_d;
         sign_q      <= sign_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
         g_q         <= g_d;
         s_q         <= s_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

`ifdef FPU_MULT_STICKY_FLAGS_EN
   logic [3:0] sticky_q, sticky_d;

   // A clear coinciding with a handshake keeps the incoming flags.
   always_comb begin
      if (flags_clr_i) begin
         sticky_d = 4'b0000;
      end else begin
         sticky_d = sticky_q;
      end
      if (hs) begin
         sticky_d = sticky_d | flags_q;
      end else begin
         sticky_d = sticky_d;
      end
   end

   // Sticky flag register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sticky_q <= 4'b0000;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky_flags_o = sticky_q;
`endif

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign result_o    = res_q;
   assign overflow_o  = flags_q[FLG_OVERFLOW];
   assign underflow_o = flags_q[FLG_UNDERFLOW];
   assign inexact_o   = flags_q[FLG_INEXACT];
   assign invalid_o   = flags_q[FLG_INVALID];

endmodule
